// File: rtl/smg_pkg.sv
// Shared display-path definitions: hex glyphs (gfedcba, active-high), digit count, scan FSM states.
// Used by both the display driver and the scan decoder so the glyph set cannot drift.
package smg_pkg;

    localparam int SMG_DIGITS = 4;

    localparam logic [6:0] SMG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SMG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SMG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SMG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SMG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SMG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SMG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SMG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SMG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SMG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SMG_GLYPH_A = 7'h77;
    localparam logic [6:0] SMG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SMG_GLYPH_C = 7'h39;
    localparam logic [6:0] SMG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SMG_GLYPH_E = 7'h79;
    localparam logic [6:0] SMG_GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } smg_state_e;

endpackage

// File: rtl/smg_glyph_dec.sv
// Glyph decoder: active-high 7-segment pattern to hex nibble plus match flag.
// Latency: combinational, no registers.
// Backpressure: none; pure function of the input pattern.
module smg_glyph_dec (
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);
    import smg_pkg::*;

    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SMG_GLYPH_0: nibble = 4'h0;
            SMG_GLYPH_1: nibble = 4'h1;
            SMG_GLYPH_2: nibble = 4'h2;
            SMG_GLYPH_3: nibble = 4'h3;
            SMG_GLYPH_4: nibble = 4'h4;
            SMG_GLYPH_5: nibble = 4'h5;
            SMG_GLYPH_6: nibble = 4'h6;
            SMG_GLYPH_7: nibble = 4'h7;
            SMG_GLYPH_8: nibble = 4'h8;
            SMG_GLYPH_9: nibble = 4'h9;
            SMG_GLYPH_A: nibble = 4'hA;
            SMG_GLYPH_B: nibble = 4'hB;
            SMG_GLYPH_C: nibble = 4'hC;
            SMG_GLYPH_D: nibble = 4'hD;
            SMG_GLYPH_E: nibble = 4'hE;
            SMG_GLYPH_F: nibble = 4'hF;
            default:     valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/smg_scan_decoder.sv
// Scan decoder: rebuilds a 16-bit hex frame from multiplexed 7-seg lines (SMG_DP_CAPTURE_EN adds dp).
// Latency: digit accepted 2+STABLE_CYC cycles after its pins settle; data_valid one cycle after the completing acceptance.
// Backpressure: none; data_valid is a one-cycle pulse and data_out holds until the next frame.
module smg_scan_decoder #(
    parameter int STABLE_CYC     = 16,
    parameter int TIMEOUT_CYC    = 500000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  smg_7_in,
    input  logic [3:0]  smg_4_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        display_lost
`ifdef SMG_DP_CAPTURE_EN
    ,
    input  logic        smg_p_in,
    output logic [3:0]  dp_out
`endif
);
    import smg_pkg::*;

`ifdef SMG_DP_CAPTURE_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif
    localparam int RW   = SW + 4;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SW-1:0]   SEG_INV   = SEG_ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};
    localparam logic [3:0]      COM_INV   = COM_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [15:0]     STABLE_M1 = 16'(STABLE_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);

    logic [RW-1:0] raw;
    logic [RW-1:0] sync1_q;
    logic [RW-1:0] sync2_q;

`ifdef SMG_DP_CAPTURE_EN
    assign raw = {smg_p_in, smg_7_in, smg_4_in};
`else
    assign raw = {smg_7_in, smg_4_in};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    logic [SW-1:0] seg_n;
    logic [3:0]    com_n;
    logic [1:0]    com_idx;
    logic          com_one;

    assign seg_n = sync2_q[RW-1:4] ^ SEG_INV;
    assign com_n = sync2_q[3:0] ^ COM_INV;

    // Anything other than exactly one active common is treated as a blank slot.
    always_comb begin
        com_idx = 2'd0;
        com_one = 1'b1;
        case (com_n)
            4'b0001: com_idx = 2'd0;
            4'b0010: com_idx = 2'd1;
            4'b0100: com_idx = 2'd2;
            4'b1000: com_idx = 2'd3;
            default: com_one = 1'b0;
        endcase
    end

    logic [SW+1:0] sample;
    logic          blank;
    logic          glyph_vld;
    logic [3:0]    glyph_nib;

    assign sample = {com_idx, seg_n};
    assign blank  = ~com_one;

    smg_glyph_dec u_glyph_dec (
        .seg    (seg_n[6:0]),
        .valid  (glyph_vld),
        .nibble (glyph_nib)
    );

    smg_state_e                     state_q;
    logic [SW+1:0]                  ref_q;
    logic [15:0]                    cnt_q;
    logic [SMG_DIGITS-1:0][3:0]     shadow_q;
    logic [SMG_DIGITS-1:0]          capt_mask_q;
    logic                           pend_err_q;
    logic                           done_q;
    logic                           done_err_q;
    logic [TO_W-1:0]                to_cnt_q;

    logic                  same;
    logic                  acc;
    logic [SMG_DIGITS-1:0] mask_nxt;
    logic                  err_nxt;

    always_comb begin
        same     = (sample == ref_q);
        acc      = (state_q == SETTLE) && !blank && same && (cnt_q == STABLE_M1);
        mask_nxt = capt_mask_q | (SMG_DIGITS'(1) << com_idx);
        err_nxt  = pend_err_q | ~glyph_vld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            capt_mask_q  <= '0;
            pend_err_q   <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
            to_cnt_q     <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            frame_err    <= 1'b0;
            display_lost <= 1'b0;
        end else begin
            data_valid <= done_q;
            done_q     <= 1'b0;
            if (done_q) begin
                data_out  <= shadow_q;
                frame_err <= done_err_q;
            end

            unique case (state_q)
                IDLE: begin
                    if (!blank) begin
                        ref_q   <= sample;
                        cnt_q   <= 16'd1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (blank) begin
                        state_q <= IDLE;
                    end else if (!same) begin
                        ref_q <= sample;
                        cnt_q <= 16'd1;
                    end else if (acc) begin
                        state_q <= HELD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                HELD: begin
                    if (blank) begin
                        state_q <= IDLE;
                    end else if (!same) begin
                        ref_q   <= sample;
                        cnt_q   <= 16'd1;
                        state_q <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // An acceptance always restarts the watchdog, so completion beats a coincident timeout.
            if (acc) begin
                shadow_q[com_idx] <= glyph_nib;
                to_cnt_q          <= '0;
                display_lost      <= 1'b0;
                if (&mask_nxt) begin
                    done_q      <= 1'b1;
                    done_err_q  <= err_nxt;
                    capt_mask_q <= '0;
                    pend_err_q  <= 1'b0;
                end else begin
                    capt_mask_q <= mask_nxt;
                    pend_err_q  <= err_nxt;
                end
            end else if (to_cnt_q != TO_MAX) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
                if (to_cnt_q == TO_MAX - TO_W'(1)) begin
                    display_lost <= 1'b1;
                    capt_mask_q  <= '0;
                    pend_err_q   <= 1'b0;
                end
            end
        end
    end

`ifdef SMG_DP_CAPTURE_EN
    logic [SMG_DIGITS-1:0] dp_shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_shadow_q <= '0;
            dp_out      <= '0;
        end else begin
            if (acc) begin
                dp_shadow_q[com_idx] <= seg_n[7];
            end
            if (done_q) begin
                dp_out <= dp_shadow_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_smg_scan_decoder.sv
// Bench for smg_scan_decoder: per-cycle comparison against a run-length model of the scan rules,
// plus literal frame expectations for the directed scenarios.
module tb_smg_scan_decoder;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  smg_7_in = 7'h7F;
    logic [3:0]  smg_4_in = 4'hF;
    logic [15:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        display_lost;
`ifdef SMG_DP_CAPTURE_EN
    logic        smg_p_in = 1'b1;
    logic [3:0]  dp_out;
`endif

    always #5 clk = ~clk;

    smg_scan_decoder #(
        .STABLE_CYC     (STABLE),
        .TIMEOUT_CYC    (TIMEOUT),
        .SEG_ACTIVE_LOW (1'b1),
        .COM_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .smg_7_in     (smg_7_in),
        .smg_4_in     (smg_4_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_err    (frame_err),
        .display_lost (display_lost)
`ifdef SMG_DP_CAPTURE_EN
        ,
        .smg_p_in     (smg_p_in),
        .dp_out       (dp_out)
`endif
    );

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int errors = 0;
    int checks = 0;
    int vcount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a digit is accepted when the same non-blank (commons, segments) sample,
    // seen two clocks late, has been present for exactly STABLE consecutive cycles.
    logic [10:0]      h0, h1, m_s, m_last;
    int               m_run, m_to, m_idx, m_nib;
    logic [3:0][3:0]  m_shadow;
    logic [3:0]       m_mask, m_com;
    logic [6:0]       m_seg;
    bit               m_err, m_pub, m_pub_err, m_bad;
    logic [15:0]      m_pub_dat;
    logic [15:0]      exp_data  = '0;
    bit               exp_valid = 0;
    bit               exp_err   = 0;
    bit               exp_lost  = 0;

    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                h0 = '0; h1 = '0; m_last = '0; m_run = 0; m_to = 0;
                m_shadow = '0; m_mask = '0; m_err = 0; m_pub = 0;
                exp_data = '0; exp_valid = 0; exp_err = 0; exp_lost = 0;
            end else begin
                m_s = h1;
                h1  = h0;
                h0  = {smg_7_in, smg_4_in};
                m_com = ~m_s[3:0];
                m_seg = ~m_s[10:4];

                exp_valid = m_pub;
                if (m_pub) begin
                    exp_data = m_pub_dat;
                    exp_err  = m_pub_err;
                    m_pub    = 0;
                end

                if ($countones(m_com) != 1) begin
                    m_run = 0;
                end else if (m_run > 0 && m_s == m_last) begin
                    if (m_run <= STABLE) m_run++;
                end else begin
                    m_run  = 1;
                    m_last = m_s;
                end

                if (m_run == STABLE) begin
                    m_idx = 0;
                    for (int b = 0; b < 4; b++) if (m_com[b]) m_idx = b;
                    m_nib = 0;
                    m_bad = 1;
                    for (int g = 0; g < 16; g++) if (glyph_tab[g] == m_seg) begin m_nib = g; m_bad = 0; end
                    m_shadow[m_idx] = 4'(m_nib);
                    m_err = m_err | m_bad;
                    m_mask[m_idx] = 1'b1;
                    m_to = 0;
                    exp_lost = 0;
                    if (m_mask == 4'hF) begin
                        m_pub     = 1;
                        m_pub_dat = m_shadow;
                        m_pub_err = m_err;
                        m_mask    = '0;
                        m_err     = 0;
                    end
                end else if (m_to < TIMEOUT) begin
                    m_to++;
                    if (m_to == TIMEOUT) begin
                        exp_lost = 1;
                        m_mask   = '0;
                        m_err    = 0;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("data_out",     data_out,     exp_data);
            check("data_valid",   data_valid,   exp_valid);
            check("frame_err",    frame_err,    exp_err);
            check("display_lost", display_lost, exp_lost);
            if (data_valid) vcount++;
        end
    end

    // Drive active-high commons/segments onto the active-low pins for n cycles.
    task automatic drive(input logic [3:0] com_ah, input logic [6:0] seg_ah, input int n);
        smg_4_in = ~com_ah;
        smg_7_in = ~seg_ah;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_pat(input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [6:0] p3, input int hold);
        drive(4'b0001, p0, hold);
        drive(4'b0010, p1, hold);
        drive(4'b0100, p2, hold);
        drive(4'b1000, p3, hold);
    endtask

    task automatic scan(input logic [15:0] v, input int hold);
        scan_pat(glyph_tab[v[3:0]], glyph_tab[v[7:4]], glyph_tab[v[11:8]], glyph_tab[v[15:12]], hold);
    endtask

    int v0;
    logic [15:0] rv;
    logic [6:0]  pat;

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  data_out,     16'h0);
        check("rst_valid", data_valid,   1'b0);
        check("rst_err",   frame_err,    1'b0);
        check("rst_lost",  display_lost, 1'b0);
        rst = 1'b0;
        drive(4'b0000, 7'h00, 5);

        v0 = vcount;
        scan(16'h1234, 40);
        check("f1234_pulses", vcount - v0, 1);
        check("f1234_data",   data_out,    16'h1234);
        check("f1234_err",    frame_err,   1'b0);

        v0 = vcount;
        scan_pat(glyph_tab[4'hD], glyph_tab[4'hC], 7'h00, glyph_tab[4'hA], 40);
        check("bad_glyph_pulses", vcount - v0, 1);
        check("bad_glyph_data",   data_out,    16'hA0CD);
        check("bad_glyph_err",    frame_err,   1'b1);

        v0 = vcount;
        for (int k = 0; k < 4; k++) begin
            drive(4'(1 << k), glyph_tab[k + 1], 10);
            drive(4'(1 << k), ~glyph_tab[k + 1], 1);
        end
        drive(4'b0011, glyph_tab[8], 40);
        drive(4'b0000, 7'h00, 3);
        check("short_and_multi_pulses", vcount - v0, 0);
        check("short_keeps_data",       data_out,    16'hA0CD);

        drive(4'b0001, glyph_tab[2], 40);
        drive(4'b0010, glyph_tab[1], 40);
        drive(4'b0000, 7'h00, 970);
        check("lost_before", display_lost, 1'b0);
        drive(4'b0000, 7'h00, 10);
        check("lost_after",  display_lost, 1'b1);
        v0 = vcount;
        scan(16'hBEEF, 40);
        check("beef_lost",   display_lost, 1'b0);
        check("beef_pulses", vcount - v0,  1);
        check("beef_data",   data_out,     16'hBEEF);

        drive(4'b0001, glyph_tab[8], 40);
        drive(4'b0010, glyph_tab[7], 40);
        drive(4'b0100, glyph_tab[6], 40);
        rst = 1'b1;
        drive(4'b0100, glyph_tab[6], 2);
        check("midrst_data",  data_out,     16'h0);
        check("midrst_valid", data_valid,   1'b0);
        check("midrst_err",   frame_err,    1'b0);
        check("midrst_lost",  display_lost, 1'b0);
        rst = 1'b0;
        v0 = vcount;
        scan(16'h5678, 40);
        check("f5678_pulses", vcount - v0, 1);
        check("f5678_data",   data_out,    16'h5678);

        for (int f = 0; f < 8; f++) begin
            rv = 16'($urandom);
            scan(rv, $urandom_range(18, 40));
        end
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0: drive(4'b0000, 7'($urandom), $urandom_range(1, 4));
                1: drive(4'($urandom), 7'($urandom), $urandom_range(1, 20));
                default: begin
                    pat = ($urandom_range(0, 7) == 0) ? 7'($urandom) : glyph_tab[$urandom_range(0, 15)];
                    drive(4'(1 << $urandom_range(0, 3)), pat, $urandom_range(3, 40));
                end
            endcase
        end
        drive(4'b0000, 7'h00, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
